noc_inter_control: RTL and testbench

//   Top-level sequencer for one NoC-attached matmul->GELU layer pass. On start it issues
//   DMA loads of activations (A) and weights (K), runs MM, requant, GELU and requant,

---
 rtl/noc_ctrl_pkg.sv | 21 ++
 rtl/noc_inter_control.sv | 148 ++++++++++++++
 tb/tb_noc_inter_control.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/noc_ctrl_pkg.sv
// Package: noc_ctrl_pkg
// Shared definitions for the NoC layer-pass sequencer: the fixed 4-bit state
// encoding (IDLE..ERROR) used by noc_inter_control and visible to debug/test.
package noc_ctrl_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE         = 4'd0,
    ST_LOAD_A       = 4'd1,
    ST_LOAD_K       = 4'd2,
    ST_MM           = 4'd3,
    ST_REQUANT_MM   = 4'd4,
    ST_GELU         = 4'd5,
    ST_REQUANT_GELU = 4'd6,
    ST_WRITE_G      = 4'd7,
    ST_DONE         = 4'd8,
    ST_ERROR        = 4'd9
  } state_t;

endpackage

// File: rtl/noc_inter_control.sv
// Module: noc_inter_control
// Top-level sequencer for one NoC-attached matmul->GELU layer pass.
// On start: load A, load K, run MM (G write DMA launched in parallel),
// requant, GELU, requant, then wait for the G write to finish.
// Ports:
//   clk, rstn                  clock (rising edge), async active-low reset
//   start                      level request, sampled in IDLE and ERROR
//   done / error               decoded from state (DONE / ERROR)
//   start_dma_a/_k/_g          1-cycle DMA launch pulses
//   start_requant_mm           1-cycle pulse launching MM-output requant
//   start_gelu                 1-cycle pulse launching GELU
//   start_requant_gelu         1-cycle pulse launching GELU-output requant
//   dma_{a,k,g}_done/_error    DMA status pulses
//   mm_done, requant_mm_done, gelu_done, requant_gelu_done  engine completions
module noc_inter_control
  import noc_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic start,
  output logic done,
  output logic error,
  output logic start_dma_a,
  output logic start_dma_k,
  output logic start_dma_g,
  output logic start_requant_mm,
  output logic start_gelu,
  output logic start_requant_gelu,
  input  logic dma_a_done,
  input  logic dma_a_error,
  input  logic dma_k_done,
  input  logic dma_k_error,
  input  logic dma_g_done,
  input  logic dma_g_error,
  input  logic mm_done,
  input  logic requant_mm_done,
  input  logic gelu_done,
  input  logic requant_gelu_done
);

  state_t state_q, state_d;
  logic   g_done_seen_q, g_done_seen_d;
  logic   start_dma_a_q, start_dma_a_d;
  logic   start_dma_k_q, start_dma_k_d;
  logic   start_dma_g_q, start_dma_g_d;
  logic   start_requant_mm_q, start_requant_mm_d;
  logic   start_gelu_q, start_gelu_d;
  logic   start_requant_gelu_q, start_requant_gelu_d;
  logic   any_dma_error;

  assign any_dma_error = dma_a_error | dma_k_error | dma_g_error;

  always_comb begin
    state_d              = state_q;
    g_done_seen_d        = g_done_seen_q;
    start_dma_a_d        = 1'b0;
    start_dma_k_d        = 1'b0;
    start_dma_g_d        = 1'b0;
    start_requant_mm_d   = 1'b0;
    start_gelu_d         = 1'b0;
    start_requant_gelu_d = 1'b0;

    // The G write runs alongside MM..REQUANT_GELU; remember an early
    // completion so WRITE_G does not wait for a pulse that already came.
    if ((state_q == ST_MM) || (state_q == ST_REQUANT_MM) ||
        (state_q == ST_GELU) || (state_q == ST_REQUANT_GELU)) begin
      if (dma_g_done) g_done_seen_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_LOAD_A;
          g_done_seen_d = 1'b0;
          start_dma_a_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERROR: begin
        if (!start) state_d = ST_IDLE;
      end
      default: begin
        // Active stages: a DMA fault wins over any same-cycle completion.
        if (any_dma_error) begin
          state_d = ST_ERROR;
        end else begin
          unique case (state_q)
            ST_LOAD_A: if (dma_a_done) begin
              state_d       = ST_LOAD_K;
              start_dma_k_d = 1'b1;
            end
            ST_LOAD_K: if (dma_k_done) begin
              state_d       = ST_MM;
              start_dma_g_d = 1'b1;
            end
            ST_MM: if (mm_done) begin
              state_d            = ST_REQUANT_MM;
              start_requant_mm_d = 1'b1;
            end
            ST_REQUANT_MM: if (requant_mm_done) begin
              state_d      = ST_GELU;
              start_gelu_d = 1'b1;
            end
            ST_GELU: if (gelu_done) begin
              state_d              = ST_REQUANT_GELU;
              start_requant_gelu_d = 1'b1;
            end
            ST_REQUANT_GELU: if (requant_gelu_done) state_d = ST_WRITE_G;
            ST_WRITE_G: if (dma_g_done || g_done_seen_q) state_d = ST_DONE;
            default: state_d = ST_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q              <= ST_IDLE;
      g_done_seen_q        <= 1'b0;
      start_dma_a_q        <= 1'b0;
      start_dma_k_q        <= 1'b0;
      start_dma_g_q        <= 1'b0;
      start_requant_mm_q   <= 1'b0;
      start_gelu_q         <= 1'b0;
      start_requant_gelu_q <= 1'b0;
    end else begin
      state_q              <= state_d;
      g_done_seen_q        <= g_done_seen_d;
      start_dma_a_q        <= start_dma_a_d;
      start_dma_k_q        <= start_dma_k_d;
      start_dma_g_q        <= start_dma_g_d;
      start_requant_mm_q   <= start_requant_mm_d;
      start_gelu_q         <= start_gelu_d;
      start_requant_gelu_q <= start_requant_gelu_d;
    end
  end

  assign done               = (state_q == ST_DONE);
  assign error              = (state_q == ST_ERROR);
  assign start_dma_a        = start_dma_a_q;
  assign start_dma_k        = start_dma_k_q;
  assign start_dma_g        = start_dma_g_q;
  assign start_requant_mm   = start_requant_mm_q;
  assign start_gelu         = start_gelu_q;
  assign start_requant_gelu = start_requant_gelu_q;

endmodule

// File: tb/tb_noc_inter_control.sv
// Testbench for noc_inter_control: table of one-cycle stimulus records with
// expected state/done/error, and a pulse scoreboard checked every falling edge.
module tb_noc_inter_control;

  logic clk = 1'b0;
  logic rstn;
  logic start;
  logic done, error;
  logic start_dma_a, start_dma_k, start_dma_g;
  logic start_requant_mm, start_gelu, start_requant_gelu;
  logic [6:0] dn;  // a,k,g,mm,rqm,gelu,rqg
  logic [2:0] er;  // a,k,g

  noc_inter_control dut (
    .clk(clk), .rstn(rstn), .start(start), .done(done), .error(error),
    .start_dma_a(start_dma_a), .start_dma_k(start_dma_k), .start_dma_g(start_dma_g),
    .start_requant_mm(start_requant_mm), .start_gelu(start_gelu),
    .start_requant_gelu(start_requant_gelu),
    .dma_a_done(dn[0]), .dma_a_error(er[0]),
    .dma_k_done(dn[1]), .dma_k_error(er[1]),
    .dma_g_done(dn[2]), .dma_g_error(er[2]),
    .mm_done(dn[3]), .requant_mm_done(dn[4]), .gelu_done(dn[5]),
    .requant_gelu_done(dn[6])
  );

  always #5 clk = ~clk;

  // pulse bits: [0]dma_a [1]dma_k [2]dma_g [3]requant_mm [4]gelu [5]requant_gelu
  logic [5:0] pulses;
  assign pulses = {start_requant_gelu, start_gelu, start_requant_mm,
                   start_dma_g, start_dma_k, start_dma_a};

  logic [3:0] st_now;
  assign st_now = dut.state_q;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [5:0] sb[$];

  typedef struct {
    int unsigned gap;
    logic        start;
    logic [6:0]  dn;
    logic [2:0]  er;
    logic [3:0]  st;
    logic        done;
    logic        error;
    logic [5:0]  pulse;
  } vec_t;

  function automatic vec_t mk(int unsigned gap, logic s, logic [6:0] d, logic [2:0] e,
                              logic [3:0] st, logic dne, logic err, logic [5:0] p);
    vec_t v;
    v.gap = gap; v.start = s; v.dn = d; v.er = e;
    v.st = st; v.done = dne; v.error = err; v.pulse = p;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every registered start pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (pulses != 6'd0) begin
      if (sb.size() == 0) chk("unexpected_pulse", {2'b0, pulses}, 8'h00);
      else chk("pulse_order", {2'b0, pulses}, {2'b0, sb.pop_front()});
    end
  end

  task automatic apply(input vec_t v, input int idx);
    repeat (v.gap) begin
      start = 1'b0; dn = '0; er = '0;
      @(posedge clk); #1;
    end
    start = v.start; dn = v.dn; er = v.er;
    if (v.pulse != 6'd0) sb.push_back(v.pulse);
    @(posedge clk); #1;
    chk($sformatf("v%0d_state", idx), {4'b0, st_now}, {4'b0, v.st});
    chk($sformatf("v%0d_done", idx), {7'b0, done}, {7'b0, v.done});
    chk($sformatf("v%0d_error", idx), {7'b0, error}, {7'b0, v.error});
    dn = '0; er = '0;
  endtask

  vec_t tbl[$];

  initial begin
    // happy path
    tbl.push_back(mk(0, 1, 7'h00, 3'h0, 1, 0, 0, 6'h01));
    tbl.push_back(mk(3, 0, 7'h01, 3'h0, 2, 0, 0, 6'h02));
    tbl.push_back(mk(3, 0, 7'h02, 3'h0, 3, 0, 0, 6'h04));
    tbl.push_back(mk(9, 0, 7'h08, 3'h0, 4, 0, 0, 6'h08));
    tbl.push_back(mk(1, 0, 7'h10, 3'h0, 5, 0, 0, 6'h10));
    tbl.push_back(mk(4, 0, 7'h20, 3'h0, 6, 0, 0, 6'h20));
    tbl.push_back(mk(1, 0, 7'h40, 3'h0, 7, 0, 0, 6'h00));
    tbl.push_back(mk(1, 0, 7'h04, 3'h0, 8, 1, 0, 6'h00));
    tbl.push_back(mk(0, 0, 7'h00, 3'h0, 0, 0, 0, 6'h00));
    // DMA A fault, exit with start low
    tbl.push_back(mk(0, 1, 7'h00, 3'h0, 1, 0, 0, 6'h01));
    tbl.push_back(mk(1, 0, 7'h00, 3'h1, 9, 0, 1, 6'h00));
    tbl.push_back(mk(0, 0, 7'h00, 3'h0, 0, 0, 0, 6'h00));
    // early G completion during GELU
    tbl.push_back(mk(0, 1, 7'h00, 3'h0, 1, 0, 0, 6'h01));
    tbl.push_back(mk(0, 0, 7'h01, 3'h0, 2, 0, 0, 6'h02));
    tbl.push_back(mk(0, 0, 7'h02, 3'h0, 3, 0, 0, 6'h04));
    tbl.push_back(mk(0, 0, 7'h08, 3'h0, 4, 0, 0, 6'h08));
    tbl.push_back(mk(0, 0, 7'h10, 3'h0, 5, 0, 0, 6'h10));
    tbl.push_back(mk(0, 0, 7'h04, 3'h0, 5, 0, 0, 6'h00));
    tbl.push_back(mk(0, 0, 7'h20, 3'h0, 6, 0, 0, 6'h20));
    tbl.push_back(mk(0, 0, 7'h40, 3'h0, 7, 0, 0, 6'h00));
    tbl.push_back(mk(0, 0, 7'h00, 3'h0, 8, 1, 0, 6'h00));
    tbl.push_back(mk(0, 0, 7'h00, 3'h0, 0, 0, 0, 6'h00));
    // stray done ignored; simultaneous K done+error -> ERROR, no G launch
    tbl.push_back(mk(0, 1, 7'h00, 3'h0, 1, 0, 0, 6'h01));
    tbl.push_back(mk(0, 0, 7'h08, 3'h0, 1, 0, 0, 6'h00));
    tbl.push_back(mk(0, 0, 7'h01, 3'h0, 2, 0, 0, 6'h02));
    tbl.push_back(mk(0, 0, 7'h02, 3'h2, 9, 0, 1, 6'h00));
    // error hold with start high, then release; error in IDLE ignored
    tbl.push_back(mk(0, 1, 7'h00, 3'h0, 9, 0, 1, 6'h00));
    tbl.push_back(mk(0, 1, 7'h00, 3'h0, 9, 0, 1, 6'h00));
    tbl.push_back(mk(0, 0, 7'h00, 3'h0, 0, 0, 0, 6'h00));
    tbl.push_back(mk(0, 0, 7'h00, 3'h1, 0, 0, 0, 6'h00));

    rstn = 1'b0; start = 1'b0; dn = '0; er = '0;
    #2;
    chk("reset_state", {4'b0, st_now}, 8'h00);
    chk("reset_outputs", {pulses, done, error}, 8'h00);
    #10 rstn = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) apply(tbl[i], i);

    // async reset while in GELU, with start_gelu still high
    apply(mk(0, 1, 7'h00, 3'h0, 1, 0, 0, 6'h01), 100);
    apply(mk(0, 0, 7'h01, 3'h0, 2, 0, 0, 6'h02), 101);
    apply(mk(0, 0, 7'h02, 3'h0, 3, 0, 0, 6'h04), 102);
    apply(mk(0, 0, 7'h08, 3'h0, 4, 0, 0, 6'h08), 103);
    apply(mk(0, 0, 7'h10, 3'h0, 5, 0, 0, 6'h10), 104);
    #6 rstn = 1'b0;
    #1;
    chk("async_rst_state", {4'b0, st_now}, 8'h00);
    chk("async_rst_outputs", {pulses, done, error}, 8'h00);
    @(posedge clk); @(posedge clk); #3 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_release_state", {4'b0, st_now}, 8'h00);
    chk("post_release_outputs", {pulses, done, error}, 8'h00);
    chk("scoreboard_drained", 8'(sb.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
